// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream frame FIFO.
// Holds the write-side state encoding and pointer full/empty tests.
package axis_pkg;

  // Write-side frame state: idle between frames, mid-frame, or discarding.
  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACTIVE = 2'd1,
    WR_DROP   = 2'd2
  } wr_state_t;

  // Pointers are zero-extended into this width before comparison.
  localparam int unsigned PTR_MAX_W = 32;

  // Full: pointers (aw+1 bits) differ only in their wrap bit.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] a,
                                    input logic [PTR_MAX_W-1:0] b,
                                    input int unsigned          aw);
    logic [PTR_MAX_W-1:0] mask;
    logic [PTR_MAX_W-1:0] msb;
    msb  = PTR_MAX_W'(1) << aw;
    mask = (PTR_MAX_W'(2) << aw) - PTR_MAX_W'(1);
    return ((a ^ b) & mask) == msb;
  endfunction

  // Empty: pointers (aw+1 bits) are identical.
  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] a,
                                     input logic [PTR_MAX_W-1:0] b,
                                     input int unsigned          aw);
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(2) << aw) - PTR_MAX_W'(1);
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register only updates on rd_en, so it doubles as a holding stage.
module axis_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, held while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO. Frames become visible only after
// their tlast beat is written; frames that do not fit are dropped whole.
// Optional feature macro AXIS_FRAME_FIFO_DROP_BAD_EN: drop frames whose tlast
// beat carries tuser=1 and tie output_axis_tuser low.
module axis_frame_fifo
  import axis_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   wr_ptr_cur_reg, wr_ptr_cur_next;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  wr_state_t             state_reg, state_next;
  logic                  overflow_reg, overflow_next;
  logic                  good_reg, good_next;
  logic                  bad_reg, bad_next;
  logic                  out_valid_reg;
  logic                  beat, full_cur, empty, wr_en, rd_en, drop_bad, store_user;
  logic [WORD_WIDTH-1:0] wr_word, rd_word;

  // Never back-pressure: ready tracks reset release only.
  assign input_axis_tready = rst;
  assign beat = input_axis_tvalid & input_axis_tready;

`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
  assign drop_bad   = input_axis_tuser;
  assign store_user = 1'b0;
`else
  assign drop_bad   = 1'b0;
  assign store_user = input_axis_tuser;
`endif

  // Space check uses the registered rd_ptr: a slot freed this cycle counts next cycle.
  assign full_cur = ptr_full(PTR_MAX_W'(wr_ptr_cur_reg), PTR_MAX_W'(rd_ptr_reg), ADDR_WIDTH);
  // Reader only sees committed frames.
  assign empty    = ptr_empty(PTR_MAX_W'(wr_ptr_reg), PTR_MAX_W'(rd_ptr_reg), ADDR_WIDTH);
  assign rd_en    = !empty && (!out_valid_reg || output_axis_tready);
  assign wr_word  = {store_user, input_axis_tlast, input_axis_tkeep, input_axis_tdata};

  // Write FSM: tentative writes, commit on tlast, roll back on overflow or bad frame.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    wr_ptr_cur_next = wr_ptr_cur_reg;
    wr_en           = 1'b0;
    overflow_next   = 1'b0;
    good_next       = 1'b0;
    bad_next        = 1'b0;
    if (beat) begin
      if (state_reg == WR_DROP) begin
        if (input_axis_tlast) begin
          overflow_next = 1'b1;
          state_next    = WR_IDLE;
        end
      end else if (full_cur) begin
        wr_ptr_cur_next = wr_ptr_reg;
        if (input_axis_tlast) begin
          overflow_next = 1'b1;
          state_next    = WR_IDLE;
        end else begin
          state_next = WR_DROP;
        end
      end else begin
        wr_en           = 1'b1;
        wr_ptr_cur_next = wr_ptr_cur_reg + PTR_ONE;
        if (input_axis_tlast) begin
          state_next = WR_IDLE;
          if (drop_bad) begin
            wr_ptr_cur_next = wr_ptr_reg;
            bad_next        = 1'b1;
          end else begin
            wr_ptr_next = wr_ptr_cur_reg + PTR_ONE;
            good_next   = 1'b1;
          end
        end else begin
          state_next = WR_ACTIVE;
        end
      end
    end
  end

  // Write-side state and status pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= WR_IDLE;
      wr_ptr_reg     <= '0;
      wr_ptr_cur_reg <= '0;
      overflow_reg   <= 1'b0;
      good_reg       <= 1'b0;
      bad_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      wr_ptr_cur_reg <= wr_ptr_cur_next;
      overflow_reg   <= overflow_next;
      good_reg       <= good_next;
      bad_reg        <= bad_next;
    end
  end

  // Read side: advance rd_ptr and mark the output register full on each fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (rd_en) begin
      rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
      out_valid_reg <= 1'b1;
    end else if (output_axis_tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  axis_fifo_ram #(
    .WIDTH      (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_cur_reg[ADDR_WIDTH-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (rd_word)
  );

  // The RAM read register is the output stage; fields read as zero when idle.
  assign output_axis_tvalid = out_valid_reg;
  assign output_axis_tdata  = out_valid_reg ? rd_word[DATA_WIDTH-1:0] : '0;
  assign output_axis_tkeep  = out_valid_reg ? rd_word[DATA_WIDTH +: KEEP_WIDTH] : '0;
  assign output_axis_tlast  = out_valid_reg & rd_word[DATA_WIDTH+KEEP_WIDTH];
  assign output_axis_tuser  = out_valid_reg & rd_word[WORD_WIDTH-1];

  assign overflow   = overflow_reg;
  assign good_frame = good_reg;
  assign bad_frame  = bad_reg;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed testbench for axis_frame_fifo (ADDR_WIDTH=3, DATA_WIDTH=8).
module tb_axis_frame_fifo;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int KW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] input_axis_tdata = '0;
  logic [KW-1:0] input_axis_tkeep = '0;
  logic          input_axis_tvalid = 1'b0;
  logic          input_axis_tready;
  logic          input_axis_tlast = 1'b0;
  logic          input_axis_tuser = 1'b0;
  logic [DW-1:0] output_axis_tdata;
  logic [KW-1:0] output_axis_tkeep;
  logic          output_axis_tvalid;
  logic          output_axis_tready = 1'b0;
  logic          output_axis_tlast;
  logic          output_axis_tuser;
  logic          overflow, bad_frame, good_frame;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic       got_user[$];
  int n_good = 0;
  int n_over = 0;
  int n_bad  = 0;

  always #5 clk = ~clk;

  axis_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tkeep   (input_axis_tkeep),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .input_axis_tlast   (input_axis_tlast),
    .input_axis_tuser   (input_axis_tuser),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tkeep  (output_axis_tkeep),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .output_axis_tuser  (output_axis_tuser),
    .overflow           (overflow),
    .bad_frame          (bad_frame),
    .good_frame         (good_frame)
  );

  // Record output handshakes and status pulses mid-cycle.
  always @(negedge clk) begin
    if (output_axis_tvalid && output_axis_tready) begin
      got_data.push_back(output_axis_tdata);
      got_last.push_back(output_axis_tlast);
      got_user.push_back(output_axis_tuser);
      $display("beat out data=%02h last=%0b user=%0b", output_axis_tdata, output_axis_tlast, output_axis_tuser);
    end
    if (good_frame) n_good++;
    if (overflow)   n_over++;
    if (bad_frame)  n_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_user.delete();
    n_good = 0;
    n_over = 0;
    n_bad  = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    input_axis_tvalid = 1'b1;
    input_axis_tdata  = d;
    input_axis_tkeep  = 1'b1;
    input_axis_tlast  = last;
    input_axis_tuser  = user;
    tick();
    input_axis_tvalid = 1'b0;
    input_axis_tlast  = 1'b0;
    input_axis_tuser  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (input_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b exp 0", input_axis_tready); end
    checks++; if (output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", output_axis_tvalid); end
    checks++; if (output_axis_tdata !== 8'h00 || output_axis_tkeep !== 1'b0) begin errors++; $display("FAIL reset_tdata got %02h/%0b exp 00/0", output_axis_tdata, output_axis_tkeep); end
    checks++; if (output_axis_tlast !== 1'b0 || output_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tlast_tuser got %0b/%0b exp 0/0", output_axis_tlast, output_axis_tuser); end
    checks++; if ({overflow, bad_frame, good_frame} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %03b exp 000", {overflow, bad_frame, good_frame}); end
    rst = 1'b1;
    tick();
    checks++; if (input_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %0b exp 1", input_axis_tready); end
    checks++; if (output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL release_tvalid got %0b exp 0", output_axis_tvalid); end
    $display("reset test done");
  endtask

  task automatic test_latency();
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 + i), (i == 3), 1'b0);
    checks++; if (output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL latency_n1_tvalid got %0b exp 0", output_axis_tvalid); end
    tick();
    checks++; if (output_axis_tvalid !== 1'b1 || output_axis_tdata !== 8'h11 || output_axis_tkeep !== 1'b1) begin
      errors++; $display("FAIL latency_n2 got v=%0b d=%02h k=%0b exp v=1 d=11 k=1", output_axis_tvalid, output_axis_tdata, output_axis_tkeep);
    end
    repeat (6) tick();
    checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL latency_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== 8'(8'h11 + i) || gl !== (i == 3)) begin errors++; $display("FAIL latency_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, 8'(8'h11 + i), (i == 3)); end
    end
    checks++; if (n_good !== 1) begin errors++; $display("FAIL latency_good got %0d exp 1", n_good); end
    $display("latency test done");
  endtask

  task automatic test_partial();
    logic       seen;
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h21 + i), 1'b0, 1'b0);
    seen = 1'b0;
    repeat (12) begin tick(); if (output_axis_tvalid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL partial_hold got tvalid_seen=%0b exp 0", seen); end
    send_beat(8'h24, 1'b1, 1'b0);
    repeat (6) tick();
    checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL partial_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== 8'(8'h21 + i) || gl !== (i == 3)) begin errors++; $display("FAIL partial_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, 8'(8'h21 + i), (i == 3)); end
    end
    $display("partial frame test done");
  endtask

  task automatic test_overflow();
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(8'(8'h31 + i), (i == 5), 1'b0);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) send_beat(8'(8'h41 + i), (i == 3), 1'b0);
    tick();
    checks++; if (n_good !== 1 || n_over !== 1) begin errors++; $display("FAIL ovf_pulses got good=%0d over=%0d exp 1/1", n_good, n_over); end
    checks++; if (output_axis_tvalid !== 1'b1 || output_axis_tdata !== 8'h31 || got_data.size() !== 0) begin
      errors++; $display("FAIL ovf_held got v=%0b d=%02h n=%0d exp v=1 d=31 n=0", output_axis_tvalid, output_axis_tdata, got_data.size());
    end
    output_axis_tready = 1'b1;
    repeat (10) tick();
    checks++; if (got_data.size() !== 6) begin errors++; $display("FAIL ovf_count got %0d exp 6", got_data.size()); end
    for (int i = 0; i < 6; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== 8'(8'h31 + i) || gl !== (i == 5)) begin errors++; $display("FAIL ovf_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, 8'(8'h31 + i), (i == 5)); end
    end
    $display("overflow test done");
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp_d;
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h51 + i), (i == 7), 1'b0);
    repeat (2) tick();
    send_beat(8'h61, 1'b1, 1'b0);
    send_beat(8'h62, 1'b1, 1'b0);
    tick();
    checks++; if (n_good !== 2 || n_over !== 1) begin errors++; $display("FAIL full_pulses got good=%0d over=%0d exp 2/1", n_good, n_over); end
    output_axis_tready = 1'b1;
    repeat (14) tick();
    checks++; if (got_data.size() !== 9) begin errors++; $display("FAIL full_count got %0d exp 9", got_data.size()); end
    for (int i = 0; i < 9; i++) begin
      exp_d = (i == 8) ? 8'h61 : 8'(8'h51 + i);
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== exp_d || gl !== (i >= 7)) begin errors++; $display("FAIL full_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, exp_d, (i >= 7)); end
    end
    // A frame one beat longer than the FIFO can never fit.
    clear_mon();
    for (int i = 0; i < 9; i++) send_beat(8'(8'hC1 + i), (i == 8), 1'b0);
    repeat (6) tick();
    checks++; if (n_over !== 1 || n_good !== 0 || got_data.size() !== 0) begin
      errors++; $display("FAIL oversize got over=%0d good=%0d n=%0d exp 1/0/0", n_over, n_good, got_data.size());
    end
    $display("full boundary test done");
  endtask

  task automatic test_tuser();
    logic [7:0] gd;
    logic       gu;
    logic [7:0] exp_d[4];
    logic       exp_u[4];
    int         exp_n;
    clear_mon();
    output_axis_tready = 1'b1;
    send_beat(8'h71, 1'b0, 1'b0);
    send_beat(8'h72, 1'b1, 1'b1);
    send_beat(8'h81, 1'b0, 1'b0);
    send_beat(8'h82, 1'b1, 1'b0);
    repeat (8) tick();
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
    exp_n = 2;
    exp_d[0] = 8'h81; exp_d[1] = 8'h82; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    exp_u[0] = 1'b0;  exp_u[1] = 1'b0;  exp_u[2] = 1'b0;  exp_u[3] = 1'b0;
    checks++; if (n_bad !== 1 || n_good !== 1) begin errors++; $display("FAIL tuser_pulses got bad=%0d good=%0d exp 1/1", n_bad, n_good); end
`else
    exp_n = 4;
    exp_d[0] = 8'h71; exp_d[1] = 8'h72; exp_d[2] = 8'h81; exp_d[3] = 8'h82;
    exp_u[0] = 1'b0;  exp_u[1] = 1'b1;  exp_u[2] = 1'b0;  exp_u[3] = 1'b0;
    checks++; if (n_bad !== 0 || n_good !== 2) begin errors++; $display("FAIL tuser_pulses got bad=%0d good=%0d exp 0/2", n_bad, n_good); end
`endif
    checks++; if (got_data.size() !== exp_n) begin errors++; $display("FAIL tuser_count got %0d exp %0d", got_data.size(), exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gu = (i < got_user.size()) ? got_user[i] : 1'bx;
      checks++; if (gd !== exp_d[i] || gu !== exp_u[i]) begin errors++; $display("FAIL tuser_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gu, exp_d[i], exp_u[i]); end
    end
    $display("tuser test done");
  endtask

  task automatic test_stall();
    logic [7:0] pre_d;
    logic       pre_l;
    logic       stalled;
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(8'(8'h91 + i), (i == 4), 1'b0);
    tick();
    for (int c = 0; c < 20; c++) begin
      output_axis_tready = (c % 2 == 0);
      pre_d   = output_axis_tdata;
      pre_l   = output_axis_tlast;
      stalled = output_axis_tvalid && !output_axis_tready;
      tick();
      if (stalled) begin
        checks++;
        if (output_axis_tvalid !== 1'b1 || output_axis_tdata !== pre_d || output_axis_tlast !== pre_l) begin
          errors++; $display("FAIL stall_hold cyc%0d got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b", c, output_axis_tvalid, output_axis_tdata, output_axis_tlast, pre_d, pre_l);
        end
      end
    end
    output_axis_tready = 1'b1;
    checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL stall_count got %0d exp 5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== 8'(8'h91 + i) || gl !== (i == 4)) begin errors++; $display("FAIL stall_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, 8'(8'h91 + i), (i == 4)); end
    end
    $display("stall test done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] gd;
    logic       gl;
    clear_mon();
    output_axis_tready = 1'b1;
    send_beat(8'hA1, 1'b0, 1'b0);
    send_beat(8'hA2, 1'b0, 1'b0);
    input_axis_tvalid = 1'b1;
    input_axis_tdata  = 8'hA3;
    #2 rst = 1'b0;
    #1;
    checks++; if (output_axis_tvalid !== 1'b0 || output_axis_tdata !== 8'h00 || input_axis_tready !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got v=%0b d=%02h rdy=%0b exp 0/00/0", output_axis_tvalid, output_axis_tdata, input_axis_tready);
    end
    input_axis_tvalid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    repeat (4) tick();
    checks++; if (output_axis_tvalid !== 1'b0 || got_data.size() !== 0) begin
      errors++; $display("FAIL midrst_empty got v=%0b n=%0d exp 0/0", output_axis_tvalid, got_data.size());
    end
    for (int i = 0; i < 3; i++) send_beat(8'(8'hB1 + i), (i == 2), 1'b0);
    repeat (6) tick();
    checks++; if (got_data.size() !== 3 || n_good !== 1 || n_over !== 0) begin
      errors++; $display("FAIL midrst_count got n=%0d good=%0d over=%0d exp 3/1/0", got_data.size(), n_good, n_over);
    end
    for (int i = 0; i < 3; i++) begin
      gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
      gl = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (gd !== 8'(8'hB1 + i) || gl !== (i == 2)) begin errors++; $display("FAIL midrst_beat%0d got %02h/%0b exp %02h/%0b", i, gd, gl, 8'(8'hB1 + i), (i == 2)); end
    end
    $display("mid-frame reset test done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_partial();
    test_overflow();
    test_full_boundary();
    test_tuser();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Store-and-forward AXI-Stream frame FIFO that sits directly downstream of the bus-width adapter and consumes its narrow output stream. A frame becomes visible at the output only after its tlast beat is written, so downstream logic never sees a partial frame. Frames that cannot fit are discarded whole instead of back-pressuring the adapter. Per-frame status pulses go to the MAC statistics counters.

## Interface
- ADDR_WIDTH, 12, log2 of FIFO depth in beats (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 8, tdata width; must equal the adapter's OUTPUT_DATA_WIDTH
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- input_axis_tdata  in  DATA_WIDTH  write-side data
- input_axis_tkeep  in  KEEP_WIDTH  write-side byte enables
- input_axis_tvalid  in  1  write-side valid
- input_axis_tready  out  1  write-side ready
- input_axis_tlast  in  1  end of frame
- input_axis_tuser  in  1  bad-frame marker, sampled on the tlast beat
- output_axis_tdata  out  DATA_WIDTH  read-side data
- output_axis_tkeep  out  KEEP_WIDTH  read-side byte enables
- output_axis_tvalid  out  1  read-side valid
- output_axis_tready  in  1  read-side ready
- output_axis_tlast  out  1  end of frame
- output_axis_tuser  out  1  bad-frame marker
- overflow  out  1  one-cycle pulse when a frame is dropped for lack of space
- bad_frame  out  1  one-cycle pulse when a frame is dropped for tuser (see Configuration)
- good_frame  out  1  one-cycle pulse when a frame is committed

## Operation
- Memory word is {tuser, tlast, tkeep, tdata}, DATA_WIDTH+KEEP_WIDTH+2 bits wide, 2^ADDR_WIDTH entries.
- Pointers are ADDR_WIDTH+1 bits, with the MSB used for wrap: wr_ptr (committed), wr_ptr_cur (tentative), rd_ptr.
- full_cur: wr_ptr_cur and rd_ptr differ only in MSB.
- empty: wr_ptr == rd_ptr.
- input_axis_tready = 1 whenever rst is deasserted. The block never back-pressures; it drops frames instead.
- Write FSM states:
  - WR_IDLE/WR_ACTIVE: each accepted beat is written at wr_ptr_cur, which then increments. On a tlast beat, wr_ptr <= wr_ptr_cur+1 and good_frame pulses.
  - WR_DROP: entered when a beat arrives while full_cur. wr_ptr_cur <= wr_ptr, and all beats are discarded up to and including tlast, which pulses overflow and returns to WR_IDLE.
  - A single beat that is both first and tlast while full goes straight to a dropped frame: overflow pulses and the state stays WR_IDLE.
- Read side: one-entry output register.
  - When the output register is empty or being consumed (tready & tvalid) and !empty, read mem[rd_ptr] into the output register and increment rd_ptr.
  - Reads compare rd_ptr against committed wr_ptr only.
- Simultaneous write and read near full: full_cur uses the registered rd_ptr, so space freed this cycle counts only from the next cycle.
- A frame longer than 2^ADDR_WIDTH beats always drops.

## Timing
- Reset values:
  - All pointers 0, state WR_IDLE.
  - output_axis_tvalid/tlast/tuser 0; tdata/tkeep 0.
  - overflow/bad_frame/good_frame 0; input_axis_tready 0 while rst is low.
- Latency: with the FIFO empty and a tlast handshake in cycle N, output_axis_tvalid rises in cycle N+2 carrying the first beat.
- Throughput: one beat per cycle on both sides.
- Output holds tdata/tkeep/tlast/tuser stable while tvalid & !tready.
- Reset asserted mid-frame: the partial frame is lost, nothing is emitted, and the FIFO is empty after release.

## Configuration
- AXIS_FRAME_FIFO_DROP_BAD_EN defined:
  - A frame whose tlast beat has tuser=1 is discarded: wr_ptr_cur <= wr_ptr, bad_frame pulses, good_frame does not.
  - output_axis_tuser is tied to 0.
- Not defined:
  - All complete frames commit and tuser passes through unchanged.
  - bad_frame is tied to 0.

## Structure
- Shared package axis_pkg holds:
  - the write-state enumeration;
  - a ptr_full/ptr_empty helper.
- Sub-module axis_fifo_ram: simple dual-port synchronous RAM with one write port and one registered read port, parameterised by width and depth.

## Test plan
- Reset, then a 4-beat frame 0x11..0x14 with tlast on 0x14, downstream tready=1:
  - tvalid rises 2 cycles after the tlast handshake;
  - beats 0x11..0x14 appear in order, with tlast on 0x14;
  - good_frame pulses once.
- No tlast after 3 beats: output_axis_tvalid stays 0 indefinitely. Sending tlast then releases all 4 beats.
- ADDR_WIDTH=3, downstream tready=0:
  - a 6-beat frame commits;
  - a following 4-beat frame gets overflow on its tlast and is not emitted;
  - with tready=1, only the 6 beats appear.
- With the macro defined, frame A (tuser=1 on tlast) then frame B (tuser=0): bad_frame pulses for A, and only B is emitted, with output_axis_tuser=0. Without the macro, both frames appear and A's last beat has tuser=1.
- Downstream tready toggling 1,0,1,0 during a 5-beat frame: data stays stable while stalled, and no beat is lost or duplicated.
- Assert rst low mid-frame and release: all outputs return to reset values, and the next frame passes intact.
